// File: rtl/posit_mult_scheduler_pkg.sv
// posit_mult_pkg: shared definitions for the posit multiplier scheduler.
//   POSIT_N / POSIT_ES : default posit word width and exponent field width
//   ID_W               : tag id width, wide enough for up to 8 requesters
//   tag_t              : {valid, id} entry carried alongside each issued multiply
//   POSIT_ZERO/INF     : the two special posit encodings (32-bit form)
package posit_mult_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int ID_W     = 3;

  localparam logic [31:0] POSIT_ZERO = 32'h0000_0000;
  localparam logic [31:0] POSIT_INF  = 32'h8000_0000;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/posit_mult_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter, one grant per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector (already masked by the caller)
//   advance    : the current grant was consumed this cycle; move the pointer
//   grant      : one-hot (or zero) grant
//   grant_id   : binary index of the granted requester
// After reset requester 0 has highest priority; after granting k the search
// starts at (k+1) mod NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        grant    = NREQ'(1) << cand;
        grant_id = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/posit_mult_scheduler.sv
// posit_mult_scheduler: shares one pipelined posit multiplier between NREQ
// requesters and routes each result back to the requester that issued it.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready            : per-requester handshake (ready is combinational)
//   req_in1/req_in2                : packed operands, requester k at [k*N +: N]
//   hold                           : blocks new grants, in-flight work continues
//   mult_start/mult_in1/mult_in2   : issue port to the multiplier
//   mult_result/inf/zero/done      : multiplier outputs, done LATENCY cycles after start
//   resp_valid                     : one-hot strobe to the owning requester
//   resp_result/resp_inf/resp_zero : shared result bus, holds last value
//   busy                           : operations in flight
//   err_sync                       : sticky, mult_done disagreed with the tag pipeline
module posit_mult_scheduler import posit_mult_pkg::*; #(
  parameter int N       = POSIT_N,
  parameter int ES      = POSIT_ES,
  parameter int NREQ    = 4,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  input  logic              hold,
  output logic              mult_start,
  output logic [N-1:0]      mult_in1,
  output logic [N-1:0]      mult_in2,
  input  logic [N-1:0]      mult_result,
  input  logic              mult_inf,
  input  logic              mult_zero,
  input  logic              mult_done,
  output logic [NREQ-1:0]   resp_valid,
  output logic [N-1:0]      resp_result,
  output logic              resp_inf,
  output logic              resp_zero,
  output logic              busy,
  output logic              err_sync
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LATENCY + 2) + 1;
  localparam bit ES_OK = (ES >= 0) && (ES < N);
  localparam logic [N-1:0] WORD_RST = ES_OK ? N'(POSIT_ZERO) : '0;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            fire;
  logic [N-1:0]    op1, op2;
  logic            vld_p0;
  logic [IDW-1:0]  id_p0;
  tag_t            tag_p1 [LATENCY];
  tag_t            tail;
  logic [NREQ-1:0] resp_sel;
  logic [CW-1:0]   inflight;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid & {NREQ{~hold}}),
    .advance  (fire),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Ready is forced low while reset is asserted.
  assign req_ready = grant & {NREQ{rst_n}};
  assign fire      = |req_ready;

  always_comb begin
    op1 = '0;
    op2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        op1 = req_in1[k*N +: N];
        op2 = req_in2[k*N +: N];
      end
    end
  end

  // Stage p0: issue register feeding the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      id_p0    <= '0;
      mult_in1 <= WORD_RST;
      mult_in2 <= WORD_RST;
    end else begin
      vld_p0 <= fire;
      if (fire) begin
        id_p0    <= grant_id;
        mult_in1 <= op1;
        mult_in2 <= op2;
      end
    end
  end

  assign mult_start = vld_p0;

  // Stage p1: LATENCY-deep tag shift register; the tail lines up with mult_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tag_p1[i] <= '0;
    end else begin
      tag_p1[0] <= {vld_p0, ID_W'(id_p0)};
      for (int i = 1; i < LATENCY; i++) tag_p1[i] <= tag_p1[i-1];
    end
  end

  assign tail = tag_p1[LATENCY-1];

  always_comb begin
    resp_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      resp_sel[k] = tail.valid && (tail.id == ID_W'(k));
    end
  end

  // Stage p2: response register, delivery follows the tag even if done disagrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= '0;
      resp_result <= WORD_RST;
      resp_inf    <= 1'b0;
      resp_zero   <= 1'b0;
    end else begin
      resp_valid <= resp_sel;
      if (tail.valid) begin
        resp_result <= mult_result;
        resp_inf    <= mult_inf;
        resp_zero   <= mult_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      err_sync <= 1'b0;
    end else begin
      case ({fire, tail.valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (mult_done != tail.valid) err_sync <= 1'b1;
    end
  end

  assign busy = (inflight != '0);

endmodule
